// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the read master.
//   htrans_t / hburst_t : bus transfer and burst encodings
//   HSIZE_WORD          : 32-bit transfer size
//   HRESP_OKAY/ERROR    : slave response codes
//   rd_state_t          : read FSM states
//   ahb_next_addr()     : next beat address for INCR4 / WRAP4
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011
    } hburst_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_PIPE,
        RD_LAST
    } rd_state_t;

    // WRAP4 keeps bits [31:4] and rolls the word index within the 16-byte block.
    function automatic logic [31:0] ahb_next_addr(input logic [31:0] addr, input logic wrap);
        logic [1:0] idx;
        idx = addr[3:2] + 2'd1;
        return wrap ? {addr[31:4], idx, 2'b00} : addr + 32'd4;
    endfunction

endpackage

// File: rtl/ahb_rd_fifo.sv
// ahb_rd_fifo: synchronous first-word-fall-through receive FIFO.
//   clk_master, rst_master : clock, async active-high reset
//   push_i / push_data_i   : write one entry (ignored when full)
//   pop_i                  : drop the head entry (ignored when empty)
//   pop_data_o             : head entry, 0 while empty
//   count_o, full_o, empty_o : occupancy status
module ahb_rd_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 32
) (
    input  logic                        clk_master,
    input  logic                        rst_master,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           push_data_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok_d, pop_ok_d;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign count_o    = count_q;
    assign push_ok_d  = push_i && !full_o;
    assign pop_ok_d   = pop_i && !empty_o;
    // Head is gated so an emptied FIFO reads back as zero without clearing storage.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_master) begin
        if (push_ok_d) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_master or posedge rst_master) begin
        if (rst_master) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_d) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok_d)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok_d, pop_ok_d})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/master_ahb_read.sv
// master_ahb_read: AHB-Lite read initiator issuing SINGLE / INCR4 / WRAP4
// transfers and capturing HRDATA into a FWFT receive FIFO.
//   clk_master, rst_master          : clock, async active-high reset
//   HREADY, HRESP, HRDATA           : slave response
//   start, addr_top, beat_length,
//   wrap_enb                        : transaction request (accepted in IDLE only)
//   rd_pop, rd_data, fifo_empty/full: consumer side of the receive FIFO
//   HADDR, HWRITE, HSIZE, HBURST,
//   HTRANS                          : registered address-phase outputs
//   busy, done, error               : status; done/error are one-cycle pulses
// Optional macro AHB_RD_WAITCNT_EN adds wait_cnt[15:0], a saturating count of
// data-phase wait states for the current transaction.
module master_ahb_read
    import ahb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk_master,
    input  logic              rst_master,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              start,
    input  logic [31:0]       addr_top,
    input  logic [3:0]        beat_length,
    input  logic              wrap_enb,
    input  logic              rd_pop,
    output logic [31:0]       HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] rd_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              busy,
    output logic              done,
`ifdef AHB_RD_WAITCNT_EN
    output logic [15:0]       wait_cnt,
`endif
    output logic              error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_t   state_q;
    htrans_t     htrans_q;
    hburst_t     hburst_q;
    logic [31:0] haddr_q;
    logic [2:0]  addr_cnt_q;   // address phases issued so far, including the current one
    logic        burst_q, wrap_q, busy_q, done_q, error_q;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   need_d;
    logic          accept_d, data_phase_d, push_d, resp_err_d;

    always_comb begin
        // Reserve room for every beat up front so the FIFO can never overflow.
        need_d       = {1'b0, fifo_count} + ((beat_length == 4'd4) ? (CW+1)'(4) : (CW+1)'(1));
        accept_d     = (state_q == RD_IDLE) && start &&
                       ((beat_length == 4'd1) || (beat_length == 4'd4)) &&
                       (need_d <= (CW+1)'(FIFO_DEPTH));
        data_phase_d = (state_q == RD_PIPE) || (state_q == RD_LAST);
        resp_err_d   = data_phase_d && HREADY && (HRESP == HRESP_ERROR);
        push_d       = data_phase_d && HREADY && (HRESP == HRESP_OKAY);
    end

    always_ff @(posedge clk_master or posedge rst_master) begin
        if (rst_master) begin
            state_q    <= RD_IDLE;
            htrans_q   <= HTRANS_IDLE;
            hburst_q   <= HBURST_SINGLE;
            haddr_q    <= '0;
            addr_cnt_q <= '0;
            burst_q    <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (resp_err_d) begin
                // Abort: the errored beat is dropped and remaining beats are cancelled.
                state_q  <= RD_IDLE;
                htrans_q <= HTRANS_IDLE;
                hburst_q <= HBURST_SINGLE;
                busy_q   <= 1'b0;
                error_q  <= 1'b1;
            end else begin
                case (state_q)
                    RD_IDLE: if (accept_d) begin
                        state_q    <= RD_ADDR;
                        haddr_q    <= {addr_top[31:2], 2'b00};
                        htrans_q   <= HTRANS_NONSEQ;
                        hburst_q   <= (beat_length == 4'd4) ? (wrap_enb ? HBURST_WRAP4 : HBURST_INCR4)
                                                            : HBURST_SINGLE;
                        burst_q    <= (beat_length == 4'd4);
                        wrap_q     <= wrap_enb;
                        addr_cnt_q <= 3'd1;
                        busy_q     <= 1'b1;
                    end
                    RD_ADDR: if (HREADY) begin
                        if (burst_q) begin
                            state_q    <= RD_PIPE;
                            haddr_q    <= ahb_next_addr(haddr_q, wrap_q);
                            htrans_q   <= HTRANS_SEQ;
                            addr_cnt_q <= addr_cnt_q + 3'd1;
                        end else begin
                            state_q  <= RD_LAST;
                            htrans_q <= HTRANS_IDLE;
                        end
                    end
                    RD_PIPE: if (HREADY) begin
                        if (addr_cnt_q == 3'd4) begin
                            state_q  <= RD_LAST;
                            htrans_q <= HTRANS_IDLE;
                        end else begin
                            haddr_q    <= ahb_next_addr(haddr_q, wrap_q);
                            htrans_q   <= HTRANS_SEQ;
                            addr_cnt_q <= addr_cnt_q + 3'd1;
                        end
                    end
                    RD_LAST: if (HREADY) begin
                        state_q  <= RD_IDLE;
                        hburst_q <= HBURST_SINGLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                    default: state_q <= RD_IDLE;
                endcase
            end
        end
    end

`ifdef AHB_RD_WAITCNT_EN
    logic [15:0] wait_cnt_q;

    always_ff @(posedge clk_master or posedge rst_master) begin
        if (rst_master)                                                   wait_cnt_q <= '0;
        else if (accept_d)                                                wait_cnt_q <= '0;
        else if (data_phase_d && !HREADY && (wait_cnt_q != 16'hFFFF))     wait_cnt_q <= wait_cnt_q + 16'd1;
    end

    assign wait_cnt = wait_cnt_q;
`endif

    ahb_rd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk_master  (clk_master),
        .rst_master  (rst_master),
        .push_i      (push_d),
        .push_data_i (HRDATA),
        .pop_i       (rd_pop),
        .pop_data_o  (rd_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign HADDR  = haddr_q;
    assign HWRITE = 1'b0;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = hburst_q;
    assign HTRANS = htrans_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule
